// File: rtl/prio_pkg.sv
// Shared types and limits for the sticky-pending priority encoder.
package prio_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam int unsigned PRIO_MIN_N = 2;
  localparam int unsigned PRIO_MAX_N = 64;

endpackage

// File: rtl/prio_find_msb.sv
// Combinational highest-set-bit finder: index of the top set bit plus a found flag.
module prio_find_msb #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  // Ascending scan; later (higher) hits overwrite earlier ones.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_enc_pending.sv
// Sticky-pending priority encoder with valid/ready offer of the highest pending index.
// Optional PRIO_MASK_EN adds a mask input that excludes bits from selection only.
module prio_enc_pending
  import prio_pkg::*;
#(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
`ifdef PRIO_MASK_EN
  input  logic [N-1:0] mask,
`endif
  output logic         valid,
  output logic [W-1:0] idx,
  input  logic         ready,
  output logic [N-1:0] pending,
  output logic         overflow
);

  generate
    if (N < PRIO_MIN_N || N > PRIO_MAX_N) begin : g_bad_n
      $error("prio_enc_pending: N out of supported range");
    end
  endgenerate

  state_t       state;
  logic [N-1:0] clr;
  logic [N-1:0] cand;
  logic [N-1:0] sel;
  logic [W-1:0] msb_idx;
  logic         msb_found;

  // cand equals pending outside an accept, so one finder serves both the
  // fresh offer from IDLE and the back-to-back successor on acceptance.
  always_comb begin
    clr = '0;
    if (valid && ready) clr[idx] = 1'b1;
    cand = pending & ~clr;
`ifdef PRIO_MASK_EN
    sel = cand & ~mask;
`else
    sel = cand;
`endif
  end

  prio_find_msb #(.N(N)) u_find_msb (
    .vec   (sel),
    .idx   (msb_idx),
    .found (msb_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= 1'b0;
      idx      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= cand | req;
      overflow <= |(req & cand);
      case (state)
        IDLE: begin
          if (en && msb_found) begin
            state <= OFFER;
            valid <= 1'b1;
            idx   <= msb_idx;
          end
        end
        OFFER: begin
          if (ready) begin
            if (en && msb_found) begin
              idx <= msb_idx;
            end else begin
              state <= IDLE;
              valid <= 1'b0;
              idx   <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_enc_pending.sv
// Scoreboard bench for prio_enc_pending: directed vectors, grants checked by a monitor.
module tb_prio_enc_pending;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         ready;
  logic [N-1:0] req;
  logic         valid;
  logic [2:0]   idx;
  logic [N-1:0] pending;
  logic         overflow;
`ifdef PRIO_MASK_EN
  logic [N-1:0] mask = '0;
`endif

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  prio_enc_pending #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
`ifdef PRIO_MASK_EN
    .mask     (mask),
`endif
    .valid    (valid),
    .idx      (idx),
    .ready    (ready),
    .pending  (pending),
    .overflow (overflow)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant monitor: every accepted offer must match the next expected index.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (valid === 1'b1 && ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grant_unexpected: got idx=%0d expected no grant", idx);
        end else begin
          e = exp_q.pop_front();
          check("grant_idx", int'(idx), e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b1; ready = 1'b0; req = '0;
    repeat (2) tick();
    check("rst_valid",    int'(valid),    0);
    check("rst_idx",      int'(idx),      0);
    check("rst_pending",  int'(pending),  0);
    check("rst_overflow", int'(overflow), 0);
    rst = 1'b0;
    tick();

    // Two simultaneous requests drain as 5 then 2.
    ready = 1'b1;
    exp_q.push_back(5); exp_q.push_back(2);
    req = 8'h24; tick(); req = '0;
    check("t1_pending",  int'(pending), 8'h24);
    check("t1_latency",  int'(valid),   0);
    tick();
    check("t1_valid",    int'(valid),   1);
    check("t1_idx5",     int'(idx),     5);
    tick();
    check("t1_idx2",     int'(idx),     2);
    tick();
    check("t1_idle_v",   int'(valid),   0);
    check("t1_idle_i",   int'(idx),     0);
    check("t1_idle_p",   int'(pending), 0);
    ready = 1'b0;

    // Offer held under ready=0 despite a higher request.
    req = 8'h04; tick(); req = '0;
    tick();
    check("t2_valid", int'(valid), 1);
    check("t2_idx",   int'(idx),   2);
    req = 8'h80; tick(); req = '0;
    tick();
    check("t2_hold",    int'(idx),     2);
    check("t2_pending", int'(pending), 8'h84);
    exp_q.push_back(2); exp_q.push_back(7);
    ready = 1'b1;
    tick();
    check("t2_next7", int'(idx),   7);
    check("t2_nextv", int'(valid), 1);
    tick();
    check("t2_idle", int'(valid), 0);
    ready = 1'b0;

    // Duplicate request: overflow pulse, single grant.
    req = 8'h08; tick();
    tick();
    check("t3_ovf",     int'(overflow), 1);
    check("t3_pending", int'(pending),  8'h08);
    req = '0; tick();
    check("t3_ovf_end", int'(overflow), 0);
    exp_q.push_back(3);
    ready = 1'b1;
    tick();
    check("t3_idle",    int'(valid),   0);
    check("t3_cleared", int'(pending), 0);
    tick();
    check("t3_single",  int'(valid),   0);
    ready = 1'b0;

    // Accept and re-request the same bit: set wins, offered again.
    req = 8'h10; tick(); req = '0;
    tick();
    check("t4_idx", int'(idx), 4);
    exp_q.push_back(4); exp_q.push_back(4);
    ready = 1'b1; req = 8'h10;
    tick(); req = '0;
    check("t4_pending", int'(pending),  8'h10);
    check("t4_noovf",   int'(overflow), 0);
    check("t4_gap",     int'(valid),    0);
    tick();
    check("t4_reoffer", int'(valid), 1);
    check("t4_reidx",   int'(idx),   4);
    tick();
    check("t4_done", int'(pending), 0);
    ready = 1'b0;

    // en=0 blocks offers; raising it drains 7..0 back to back.
    en = 1'b0;
    req = 8'hFF; tick(); req = '0;
    tick(); tick();
    check("t5_blocked", int'(valid),   0);
    check("t5_pending", int'(pending), 8'hFF);
    for (int i = 7; i >= 0; i--) exp_q.push_back(i);
    ready = 1'b1; en = 1'b1;
    tick();
    check("t5_first_v", int'(valid), 1);
    check("t5_first_i", int'(idx),   7);
    repeat (8) tick();
    check("t5_end_v", int'(valid),   0);
    check("t5_end_p", int'(pending), 0);
    ready = 1'b0;

    // Asynchronous reset in the middle of an offer.
    req = 8'h81; tick();
    tick(); req = '0;
    check("t6_pre_v",   int'(valid),    1);
    check("t6_pre_ovf", int'(overflow), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_valid",    int'(valid),    0);
    check("t6_idx",      int'(idx),      0);
    check("t6_pending",  int'(pending),  0);
    check("t6_overflow", int'(overflow), 0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_after", int'(valid), 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
